// File: rtl/rf_multiport_sb_if.sv
// ============================================================================
// rf_multiport_sb_if
// Bundles the register-file access signals between the pipeline (master) and
// the register file (slave).
//
// Signals:
//   rd_addr   : NUM_RD packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   : NUM_RD packed read data,    port k at [k*XLEN +: XLEN]
//   rd_hazard : per read port, register has an outstanding write
//   wr_en / wr_addr / wr_data : writeback port
//   issue_en / issue_rd       : decode issued an instruction writing issue_rd
//   ready     : clear sequence done
//   pending   : scoreboard bits (debug)
// ============================================================================
interface rf_multiport_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]        rd_hazard;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_rd;
    logic                     ready;
    logic [NUM_REGS-1:0]      pending;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rd_data, rd_hazard, ready, pending
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rd_data, rd_hazard, ready, pending
    );
endinterface

// File: rtl/rf_multiport_sb.sv
// ============================================================================
// rf_multiport_sb
// Multi-port register file with x0 hardwired to zero, a clear sequencer that
// walks every entry after reset (loading SP_INIT into SP_INDEX), and a
// per-register pending-write scoreboard that flags read hazards.
//
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding; a
// forwarded read also suppresses its hazard flag.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : rf_multiport_sb_if.slave (read ports, writeback, issue, status)
// ============================================================================
module rf_multiport_sb #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter int              ADDR_W   = $clog2(NUM_REGS),
    parameter int              NUM_RD   = 2,
    parameter int              SP_INDEX = 2,
    parameter logic [XLEN-1:0] SP_INIT  = XLEN'(32'h2ffc)
) (
    input  logic           clk,
    input  logic           reset,
    rf_multiport_sb_if.slave bus
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [XLEN-1:0]     r_rf [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic                w_run;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [XLEN-1:0]     w_wdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_INIT;
        else
            r_state <= w_state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && r_cnt == ADDR_W'(NUM_REGS - 1))
            w_state_next = ST_RUN;
    end

    // ---------------- FSM: outputs ----------------
    // The single array write port is shared between the clear walk and
    // writeback; reset blocks both so the array is untouched while held.
    always_comb begin
        w_run   = (r_state == ST_RUN);
        w_we    = 1'b0;
        w_waddr = bus.wr_addr;
        w_wdata = bus.wr_data;
        if (!w_run) begin
            w_we    = !reset;
            w_waddr = r_cnt;
            w_wdata = (r_cnt == ADDR_W'(SP_INDEX)) ? SP_INIT : '0;
        end else if (bus.wr_en && bus.wr_addr != '0) begin
            w_we    = !reset;
        end
    end

    assign bus.ready   = w_run;
    assign bus.pending = r_pending;

    // Clear counter; wraps back to 0 on the final entry, unused in RUN.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (!w_run)
            r_cnt <= r_cnt + ADDR_W'(1);
    end

    // Array storage: no reset, contents only change through the write mux.
    always_ff @(posedge clk) begin
        if (w_we)
            r_rf[w_waddr] <= w_wdata;
    end

    // ---------------- Scoreboard ----------------
    // Issue wins over writeback for the same register: the newer producer
    // is still in flight.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign r_pending[gi] = 1'b0;
            end else begin : g_bit
                always_ff @(posedge clk) begin
                    if (reset)
                        r_pending[gi] <= 1'b0;
                    else if (w_run) begin
                        if (bus.issue_en && bus.issue_rd == ADDR_W'(gi))
                            r_pending[gi] <= 1'b1;
                        else if (bus.wr_en && bus.wr_addr == ADDR_W'(gi))
                            r_pending[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // ---------------- Read ports ----------------
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_fwd;
            assign w_addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
            assign w_fwd = bus.wr_en && (bus.wr_addr == w_addr) && (w_addr != '0);
`else
            assign w_fwd = 1'b0;
`endif
            always_comb begin
                bus.rd_data[gi*XLEN +: XLEN] = '0;
                bus.rd_hazard[gi]            = 1'b0;
                if (w_run && w_addr != '0) begin
                    bus.rd_data[gi*XLEN +: XLEN] = w_fwd ? bus.wr_data : r_rf[w_addr];
                    bus.rd_hazard[gi]            = r_pending[w_addr] && !w_fwd;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rf_multiport_sb.sv
// ============================================================================
// tb_rf_multiport_sb
// Directed bench for rf_multiport_sb (default parameters, two read ports).
// The stimulus thread drives inputs just after the rising edge and queues the
// values it expects; a monitor on the falling edge pops and compares them.
// Works for both the default and the RF_BYPASS_EN build.
// ============================================================================
module tb_rf_multiport_sb;

    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    localparam int K_RDATA   = 0;
    localparam int K_HAZARD  = 1;
    localparam int K_READY   = 2;
    localparam int K_PENDING = 3;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    chk_t sb_q[$];

    rf_multiport_sb_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    rf_multiport_sb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb_q.pop_front();
            case (c.kind)
                K_RDATA:  act = bus.rd_data[c.port*XLEN +: XLEN];
                K_HAZARD: act = {31'b0, bus.rd_hazard[c.port]};
                K_READY:  act = {31'b0, bus.ready};
                default:  act = bus.pending;
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s: got %h, need %h", c.name, act, c.exp);
            end else begin
                $display("ok   %s: %h", c.name, act);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic push_chk(input string name, input int kind, input int port, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.port = port;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // Walk the clear sequence after reset has just been released; ready must
    // be low for 31 edges and high after the 32nd.
    task automatic run_clear(input string tag);
        for (int i = 1; i <= NUM_REGS; i++) begin
            tick();
            if (i == 31 || i == 32)
                push_chk($sformatf("%s_ready_e%0d", tag, i), K_READY, 0, (i == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
        set_rd(2, 5);

        // ---- reset state ----
        tick(); tick(); tick();
        push_chk("rst_ready",   K_READY,   0, 32'd0);
        push_chk("rst_pending", K_PENDING, 0, 32'd0);
        push_chk("rst_haz0",    K_HAZARD,  0, 32'd0);
        push_chk("rst_rdata1",  K_RDATA,   1, 32'd0);

        // ---- first clear sequence ----
        reset = 1'b0;
        run_clear("clr1");
        for (int a = 0; a < NUM_REGS; a += 2) begin
            set_rd(a, a + 1);
            push_chk($sformatf("clr1_x%0d", a),     K_RDATA, 0, (a == 2) ? 32'h00002ffc : 32'd0);
            push_chk($sformatf("clr1_x%0d", a + 1), K_RDATA, 1, 32'd0);
            tick();
        end
        push_chk("clr1_pending", K_PENDING, 0, 32'd0);

        // ---- reset mid-INIT, then full clear with ignored INIT traffic ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        push_chk("mid_ready", K_READY, 0, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            if (i == 25) begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 5'd20;
                bus.wr_data  = 32'h55;
                bus.issue_en = 1'b1;
                bus.issue_rd = 5'd4;
                set_rd(4, 2);
                push_chk("init_rdata1_x2", K_RDATA,  1, 32'd0);
                push_chk("init_haz0",      K_HAZARD, 0, 32'd0);
            end
            if (i == 26) begin
                bus.wr_en    = 1'b0;
                bus.issue_en = 1'b0;
            end
            tick();
            if (i == 31 || i == 32)
                push_chk($sformatf("clr2_ready_e%0d", i), K_READY, 0, (i == 32) ? 32'd1 : 32'd0);
        end
        set_rd(20, 2);
        push_chk("clr2_x20",     K_RDATA,   0, 32'd0);
        push_chk("clr2_x2",      K_RDATA,   1, 32'h00002ffc);
        push_chk("clr2_pending", K_PENDING, 0, 32'd0);
        tick();

        // ---- basic write/read, x0 discard ----
        set_rd(0, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        tick();
        bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
        tick();
        bus.wr_en = 1'b0; bus.issue_en = 1'b0;
        set_rd(5, 5);
        push_chk("x5_port0", K_RDATA, 0, 32'hDEADBEEF);
        push_chk("x5_port1", K_RDATA, 1, 32'hDEADBEEF);
        tick();
        set_rd(0, 0);
        push_chk("x0_port0",   K_RDATA,   0, 32'd0);
        push_chk("x0_port1",   K_RDATA,   1, 32'd0);
        push_chk("x0_pending", K_PENDING, 0, 32'd0);
        tick();

        // ---- scoreboard on x7 ----
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_en = 1'b0;
        set_rd(7, 7);
        push_chk("x7_pending_set", K_PENDING, 0, 32'h00000080);
        push_chk("x7_haz0",        K_HAZARD,  0, 32'd1);
        push_chk("x7_haz1",        K_HAZARD,  1, 32'd1);
        tick();
        set_rd(0, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
        tick();
        bus.wr_en = 1'b0;
        set_rd(7, 3);
        push_chk("x7_pending_clr", K_PENDING, 0, 32'd0);
        push_chk("x7_haz0_clr",    K_HAZARD,  0, 32'd0);
        push_chk("x7_data",        K_RDATA,   0, 32'h77);
        tick();
        set_rd(0, 0);
        bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h88;
        tick();
        bus.issue_en = 1'b0; bus.wr_en = 1'b0;
        set_rd(3, 7);
        push_chk("x7_same_cycle_pending", K_PENDING, 0, 32'h00000080);
        push_chk("x7_same_cycle_data",    K_RDATA,   1, 32'h88);
        tick();
        set_rd(0, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h99;
        tick();
        bus.wr_en = 1'b0;

        // ---- same-cycle write and read of x9 with pending set ----
        bus.issue_en = 1'b1; bus.issue_rd = 5'd9;
        tick();
        bus.issue_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5A5A5A5;
        set_rd(9, 9);
        push_chk("x9_pending_before", K_PENDING, 0, 32'h00000200);
`ifdef RF_BYPASS_EN
        push_chk("x9_fwd_data0", K_RDATA,  0, 32'hA5A5A5A5);
        push_chk("x9_fwd_haz0",  K_HAZARD, 0, 32'd0);
        push_chk("x9_fwd_data1", K_RDATA,  1, 32'hA5A5A5A5);
`else
        push_chk("x9_old_data0", K_RDATA,  0, 32'd0);
        push_chk("x9_old_haz0",  K_HAZARD, 0, 32'd1);
        push_chk("x9_old_data1", K_RDATA,  1, 32'd0);
`endif
        tick();
        bus.wr_en = 1'b0;
        push_chk("x9_after_data",    K_RDATA,   0, 32'hA5A5A5A5);
        push_chk("x9_after_pending", K_PENDING, 0, 32'd0);
        tick();

        // ---- reset in RUN with pending bits set ----
        set_rd(0, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h1111;
        tick();
        bus.wr_en = 1'b0;
        bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
        tick();
        bus.issue_rd = 5'd11;
        tick();
        bus.issue_en = 1'b0;
        set_rd(2, 5);
        push_chk("run_pending_set", K_PENDING, 0, 32'h00000808);
        push_chk("run_x2_written",  K_RDATA,   0, 32'h1111);
        tick();
        reset = 1'b1;
        tick();
        push_chk("rerst_pending", K_PENDING, 0, 32'd0);
        push_chk("rerst_ready",   K_READY,   0, 32'd0);
        reset = 1'b0;
        run_clear("clr3");
        push_chk("clr3_x2",      K_RDATA,   0, 32'h00002ffc);
        push_chk("clr3_x5",      K_RDATA,   1, 32'd0);
        push_chk("clr3_pending", K_PENDING, 0, 32'd0);
        tick();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d queued checks, need 0", sb_q.size());
        end
        if (n_errors == 0 && n_checks > 0)
            $display("PASS Result: errors=%0d of %0d checks", n_errors, n_checks);
        else
            $display("FAIL Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
Parametrised successor to the core register file, used by the pipelined datapath. It provides NUM_RD asynchronous read ports and one synchronous write port, with x0 hardwired to zero. It adds a multi-cycle reset-clear sequencer with a ready flag, and a per-register pending-write scoreboard that reports read hazards to the decode stage. Same-cycle write-to-read forwarding is optional.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >= 4)
ADDR_W, $clog2(NUM_REGS), register index width
NUM_RD, 2, number of read ports (1..4)
SP_INDEX, 2, index loaded with SP_INIT during the clear sequence
SP_INIT, 32'h2ffc, stack-pointer initial value

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rd_hazard  out  NUM_RD  port k: its register has an outstanding write
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback index
wr_data  in  XLEN  writeback data
issue_en  in  1  decode issued an instruction that will write issue_rd
issue_rd  in  ADDR_W  destination index of the issued instruction
ready  out  1  clear sequence done; file is usable
pending  out  NUM_REGS  scoreboard bits, for debug/print

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk.
- While reset is high: state=INIT, clear counter cnt=0, ready=0, all pending bits=0. Array contents are not touched.
- INIT state: each rising edge with reset low writes entry cnt with 0, or with SP_INIT when cnt==SP_INDEX, then increments cnt.
  - The edge that writes entry NUM_REGS-1 moves the block to RUN and sets ready=1.
  - ready therefore rises exactly NUM_REGS edges after reset falls.
- In INIT: wr_en and issue_en are ignored, all rd_data read 0, all rd_hazard read 0.
- reset asserted in RUN or mid-INIT: returns to INIT with cnt=0 and clears the scoreboard. The clear sequence restarts from entry 0.
- Read (RUN): combinational. rd_data[k] = rf[rd_addr[k]], except index 0, which always reads 0.
- Write (RUN): on a rising edge with wr_en=1 and wr_addr!=0, rf[wr_addr] <= wr_data. Writes to x0 are discarded.
- Scoreboard (RUN), per register r != 0, on a rising edge:
  - set if issue_en && issue_rd==r;
  - else cleared if wr_en && wr_addr==r;
  - else held.
  - Issue and writeback to the same r in the same cycle: the bit ends set (the newer instruction is outstanding).
  - pending[0] is constantly 0.
- rd_hazard[k]: pending[rd_addr[k]], masked to 0 for index 0. With RF_BYPASS_EN defined, it is also masked to 0 when wr_en && wr_addr==rd_addr[k] in the same cycle.
- Reset values of outputs: ready=0, pending=0, rd_hazard=0, rd_data=0.
- Multiple read ports may address the same register; each port resolves independently.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-first forwarding. In RUN, if wr_en && wr_addr==rd_addr[k] && wr_addr!=0, then rd_data[k]=wr_data in the same cycle. The hazard for that port is suppressed as stated above.
- Undefined: rd_data[k] returns the pre-edge array value. rd_hazard[k] stays asserted until the edge that clears pending.
- Scoreboard update rules are identical in both builds.

Test Plan:
- Reset for 3 cycles, then release -> ready=0 for 32 edges and 1 after the 32nd; every register reads 0 except x2=32'h00002ffc; pending=0.
- Assert reset at cnt=10 of INIT, release -> ready rises exactly 32 edges after release; an earlier write attempt during INIT leaves its register at 0.
- RUN: write x5=32'hDEADBEEF, then read it on ports 0 and 1 -> both return DEADBEEF. Write x0=32'h1234 -> x0 reads 0; pending[0] stays 0.
- issue_rd=7 -> pending[7]=1 and rd_hazard=1 on any port with rd_addr=7. Later wr_en to x7 -> pending[7]=0 after that edge. Same-cycle issue_rd=7 with wr_addr=7 -> pending[7] stays 1.
- Same-cycle write x9=32'hA5A5A5A5 with rd_addr[0]=9, pending[9]=1:
  - RF_BYPASS_EN build -> rd_data[0]=A5A5A5A5, rd_hazard[0]=0;
  - non-bypass build -> old value returned, rd_hazard[0]=1.
- Reset in RUN with pending bits set -> all pending bits clear and the clear sequence restarts; x2 reloads 32'h2ffc.
